// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states, word geometry.
// No logic beyond a pure alignment helper; nothing here is clocked.
// Imported by the top and the lane alignment sub-module.
package lsu_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } lsu_state_e;

   // True when the size is illegal or the byte offset breaks natural alignment.
   function automatic logic bad_alignment(input logic [1:0] size, input logic [1:0] offs);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = offs[0];
         SIZE_WORD: bad = (offs != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Lane steering between a 32-bit memory word and a byte/half/word access.
// Purely combinational; produces both the extended load value and the merged store word.
// No handshake; the caller chooses which output it uses.
module lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        byte_sign;
   logic        half_sign;

   // Pick the addressed little-endian lane and extend it to a full word.
   always_comb begin
      byte_lane   = word_i[{addr_i, 3'b000} +: 8];
      half_lane   = addr_i[1] ? word_i[31:16] : word_i[15:0];
      byte_sign   = byte_lane[7] & ~unsigned_i;
      half_sign   = half_lane[15] & ~unsigned_i;
      load_data_o = 32'h0;
      case (size_i)
         SIZE_BYTE: load_data_o = {{24{byte_sign}}, byte_lane};
         SIZE_HALF: load_data_o = {{16{half_sign}}, half_lane};
         SIZE_WORD: load_data_o = word_i;
         default:   load_data_o = 32'h0;
      endcase
   end

   // Overwrite only the addressed lane of the word with the right-aligned store data.
   always_comb begin
      merged_o = word_i;
      case (size_i)
         SIZE_BYTE: merged_o[{addr_i, 3'b000} +: 8] = store_data_i[7:0];
         SIZE_HALF: begin
            if (addr_i[1]) merged_o[31:16] = store_data_i[15:0];
            else           merged_o[15:0]  = store_data_i[15:0];
         end
         SIZE_WORD: merged_o = store_data_i;
         default:   merged_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide memory without byte enables.
// Latency accept->resp: error 1, load 2, word store 2, sub-word store 3 (read-modify-write).
// One request in flight; req_ready low while busy; response is never back-pressured.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_address,
   input  logic [31:0] req_write_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_error,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int OFFS_W = $clog2(WORD_BYTES);

   lsu_state_e  state_q;
   logic        write_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic [31:0] resp_data_q;
   logic        resp_error_q;

   logic        req_err_d;
   logic        accept_d;
   logic [31:0] align_word;
   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        mem_busy;

   // Screen the incoming request so a bad one never reaches memory.
   always_comb begin
      accept_d  = req_valid && (state_q == IDLE);
      req_err_d = bad_alignment(req_size, req_address[1:0])
                  || (req_address[31:2] >= 30'(MEM_WORDS));
   end

   // During READ the live memory word is steered for the load result; afterwards
   // the captured copy is the base for the store merge.
   assign align_word = (state_q == READ) ? mem_read_data : word_q;

   lane_align u_lane_align (
      .word_i       (align_word),
      .addr_i       (addr_q[1:0]),
      .size_i       (size_q),
      .unsigned_i   (unsigned_q),
      .store_data_i (wdata_q),
      .load_data_o  (load_data),
      .merged_o     (merged_word)
   );

   // Request FSM: capture on accept, optional read, optional write, one-cycle response.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         word_q       <= 32'h0;
         resp_data_q  <= 32'h0;
         resp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  write_q    <= req_write;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  addr_q     <= req_address;
                  wdata_q    <= req_write_data;
                  if (req_err_d) begin
                     state_q      <= DONE;
                     resp_error_q <= 1'b1;
                     resp_data_q  <= 32'h0;
                  end else if (req_write && (req_size == SIZE_WORD)) begin
                     state_q <= WRITE;
                  end else begin
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               word_q <= mem_read_data;
               if (write_q) begin
                  state_q <= WRITE;
               end else begin
                  state_q     <= DONE;
                  resp_data_q <= load_data;
               end
            end
            WRITE: begin
               state_q <= DONE;
            end
            default: begin
               state_q      <= IDLE;
               resp_data_q  <= 32'h0;
               resp_error_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_busy       = (state_q == READ) || (state_q == WRITE);
   assign req_ready      = (state_q == IDLE);
   assign resp_valid     = (state_q == DONE);
   assign resp_data      = resp_data_q;
   assign resp_error     = resp_error_q;
   // Strobes are qualified with reset so an aborted operation cannot touch memory.
   assign mem_read       = reset && (state_q == READ);
   assign mem_write      = reset && (state_q == WRITE);
   assign mem_address    = mem_busy ? {addr_q[31:OFFS_W], {OFFS_W{1'b0}}} : 32'h0;
   assign mem_write_data = (state_q == WRITE) ? merged_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against an array-based reference of memory and access rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_address;
   logic [31:0] req_write_data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_error;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(256)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_address    (req_address),
      .req_write_data (req_write_data),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_error     (resp_error),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Word-wide data memory (no byte enables), with a preload port.
   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic        ld_en;
   logic [7:0]  ld_idx;
   logic [31:0] ld_val;

   always @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_val;
      else if (mem_write && (mem_address[31:2] < 30'd256)) mem[mem_address[9:2]] <= mem_write_data;
   end

   always_comb begin
      mem_read_data = 32'h0;
      if (mem_read && (mem_address[31:2] < 30'd256)) mem_read_data = mem[mem_address[9:2]];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: access rules applied to an array image of memory.
   task automatic model(input logic w, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] e_data, output logic e_err, output int e_lat,
                        output int e_rd, output int e_wr, output logic [31:0] e_wdat);
      int          idx;
      int          sh;
      logic [31:0] old;
      logic [31:0] mask;
      logic [31:0] v;
      logic        sgn;
      idx    = int'(addr >> 2);
      e_err  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= 32'd256);
      e_data = 32'h0;
      e_wdat = 32'h0;
      e_rd   = 0;
      e_wr   = 0;
      e_lat  = 1;
      if (!e_err) begin
         old = ref_mem[idx];
         if (size == 2'd0) begin
            sh = int'(addr[1:0]) * 8;  mask = 32'h0000_00FF;
         end else if (size == 2'd1) begin
            sh = int'(addr[1]) * 16;   mask = 32'h0000_FFFF;
         end else begin
            sh = 0;                    mask = 32'hFFFF_FFFF;
         end
         if (!w) begin
            v   = (old >> sh) & mask;
            sgn = (size == 2'd0) ? v[7] : v[15];
            if (!uns && size != 2'd2 && sgn) v = v | ~mask;
            e_data = v;
            e_lat  = 2;
            e_rd   = 1;
         end else begin
            e_wdat       = (old & ~(mask << sh)) | ((data & mask) << sh);
            ref_mem[idx] = e_wdat;
            e_wr         = 1;
            e_rd         = (size == 2'd2) ? 0 : 1;
            e_lat        = (size == 2'd2) ? 2 : 3;
         end
      end
   endtask

   // Present a request at a falling edge and wait (bounded) until it can be taken.
   task automatic present(input logic w, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      req_write      = w;
      req_size       = size;
      req_unsigned   = uns;
      req_address    = addr;
      req_write_data = data;
      req_valid      = 1'b1;
      for (int n = 0; n < 10 && !req_ready; n++) @(negedge clk);
   endtask

   // Called at the first falling edge after the accept edge; observes until resp_valid.
   task automatic collect(output logic [31:0] r_data, output logic r_err, output int lat,
                          output int nrd, output int nwr, output int both, output int rdy,
                          output logic [31:0] wdat);
      r_data = 32'h0; r_err = 1'b0; wdat = 32'h0;
      lat = 99; nrd = 0; nwr = 0; both = 0; rdy = 0;
      for (int i = 1; i <= 8; i++) begin
         if (mem_read) nrd++;
         if (mem_write) begin nwr++; wdat = mem_write_data; end
         if (mem_read && mem_write) both++;
         if (req_ready) rdy++;
         if (resp_valid) begin
            lat    = i;
            r_data = resp_data;
            r_err  = resp_error;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic compare(input string nm, input logic [31:0] e_data, input logic e_err,
                          input int e_lat, input int e_rd, input int e_wr, input logic [31:0] e_wdat,
                          input logic [31:0] r_data, input logic r_err, input int lat,
                          input int nrd, input int nwr, input int both, input int rdy,
                          input logic [31:0] wdat);
      check_val({nm, "_data"},  r_data,         e_data);
      check_val({nm, "_err"},   32'(r_err),     32'(e_err));
      check_val({nm, "_lat"},   32'(lat),       32'(e_lat));
      check_val({nm, "_nrd"},   32'(nrd),       32'(e_rd));
      check_val({nm, "_nwr"},   32'(nwr),       32'(e_wr));
      check_val({nm, "_both"},  32'(both),      32'h0);
      check_val({nm, "_rdy"},   32'(rdy),       32'h0);
      if (e_wr != 0) check_val({nm, "_wdat"}, wdat, e_wdat);
   endtask

   task automatic do_txn(input string nm, input logic w, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] got, output logic [31:0] got_wdat);
      logic [31:0] e_data, e_wdat, r_data, wdat;
      logic        e_err, r_err;
      int          e_lat, e_rd, e_wr, lat, nrd, nwr, both, rdy;
      model(w, size, uns, addr, data, e_data, e_err, e_lat, e_rd, e_wr, e_wdat);
      present(w, size, uns, addr, data);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      collect(r_data, r_err, lat, nrd, nwr, both, rdy, wdat);
      compare(nm, e_data, e_err, e_lat, e_rd, e_wr, e_wdat, r_data, r_err, lat, nrd, nwr, both, rdy, wdat);
      got      = r_data;
      got_wdat = wdat;
   endtask

   initial begin
      logic [31:0] got, gwd;
      logic [31:0] a_data, a_wdat, b_data, b_wdat, r_data, wdat;
      logic        a_err, b_err, r_err;
      int          a_lat, a_rd, a_wr, b_lat, b_rd, b_wr, lat, nrd, nwr, both, rdy;
      int          pulses, diffs;
      logic        w, uns;
      logic [1:0]  size;
      logic [31:0] addr, data;

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_address = 32'h0; req_write_data = 32'h0;
      ld_en = 1'b1; ld_idx = 8'd0; ld_val = 32'h0;

      // Preload memory under reset; word 4 holds the reference pattern.
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ld_idx     = 8'(i);
         ld_val     = (i == 4) ? 32'h80FF7F01 : $urandom;
         ref_mem[i] = ld_val;
      end
      @(negedge clk);
      ld_en = 1'b0;

      check_val("rst_req_ready",  32'(req_ready),  32'h1);
      check_val("rst_resp_valid", 32'(resp_valid), 32'h0);
      check_val("rst_resp_data",  resp_data,       32'h0);
      check_val("rst_resp_error", 32'(resp_error), 32'h0);
      check_val("rst_mem_read",   32'(mem_read),   32'h0);
      check_val("rst_mem_write",  32'(mem_write),  32'h0);
      check_val("rst_mem_addr",   mem_address,     32'h0);
      check_val("rst_mem_wdata",  mem_write_data,  32'h0);
      reset = 1'b1;

      // Sub-word loads with sign and zero extension.
      do_txn("lb_s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got, gwd);
      check_val("lb_s_lit", got, 32'hFFFFFF80);
      do_txn("lb_u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got, gwd);
      check_val("lb_u_lit", got, 32'h00000080);

      // Halfword read-modify-write then read back.
      do_txn("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, got, gwd);
      check_val("sh_wdat_lit", gwd, 32'hBEEF7F01);
      do_txn("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, gwd);
      check_val("lw_lit", got, 32'hBEEF7F01);

      // Restore, byte store, halfword loads.
      do_txn("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, got, gwd);
      check_val("sw_wdat_lit", gwd, 32'h80FF7F01);
      do_txn("sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h555555AA, got, gwd);
      check_val("sb_wdat_lit", gwd, 32'h80FFAA01);
      do_txn("lh_s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, got, gwd);
      check_val("lh_s_lit", got, 32'hFFFFAA01);
      do_txn("lh_u", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, got, gwd);
      check_val("lh_u_lit", got, 32'h0000AA01);

      // Error cases: misaligned word, misaligned half store, out-of-range byte.
      do_txn("e_lw",  1'b0, 2'b10, 1'b0, 32'h12,  32'h0,  got, gwd);
      do_txn("e_sh",  1'b1, 2'b01, 1'b0, 32'h401, 32'hFF, got, gwd);
      do_txn("e_lb",  1'b0, 2'b00, 1'b0, 32'h400, 32'h0,  got, gwd);
      do_txn("e_sz",  1'b0, 2'b11, 1'b0, 32'h20,  32'h0,  got, gwd);

      // Request held valid while busy: taken only once the unit is idle again.
      model(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, a_data, a_err, a_lat, a_rd, a_wr, a_wdat);
      model(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, b_data, b_err, b_lat, b_rd, b_wr, b_wdat);
      present(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      @(posedge clk);
      @(negedge clk);
      req_size = 2'b00; req_address = 32'h13;
      collect(r_data, r_err, lat, nrd, nwr, both, rdy, wdat);
      compare("held_a", a_data, a_err, a_lat, a_rd, a_wr, a_wdat, r_data, r_err, lat, nrd, nwr, both, rdy, wdat);
      @(negedge clk);
      check_val("held_ready_after_done", 32'(req_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      collect(r_data, r_err, lat, nrd, nwr, both, rdy, wdat);
      compare("held_b", b_data, b_err, b_lat, b_rd, b_wr, b_wdat, r_data, r_err, lat, nrd, nwr, both, rdy, wdat);

      // Reset during the write cycle of a byte store aborts it.
      present(1'b1, 2'b00, 1'b0, 32'h21, 32'h5A);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("abort_rd", 32'(mem_read), 32'h1);
      @(negedge clk);
      check_val("abort_wr_pre", 32'(mem_write), 32'h1);
      reset = 1'b0;
      #1;
      check_val("abort_wr_gated", 32'(mem_write), 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_val("abort_ready",  32'(req_ready),  32'h1);
      check_val("abort_rvalid", 32'(resp_valid), 32'h0);
      check_val("abort_maddr",  mem_address,     32'h0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check_val("abort_no_resp", 32'(pulses), 32'h0);
      check_val("abort_mem8", mem[8], ref_mem[8]);

      // Random traffic, including illegal sizes, misalignment and out-of-range words.
      for (int t = 0; t < 300; t++) begin
         w    = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 15) == 0) addr = addr + 32'h400;
         data = $urandom;
         do_txn("rnd", w, size, uns, addr, data, got, gwd);
      end

      @(negedge clk);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check_val("mem_final_diffs", 32'(diffs), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute/memory stage and the word-wide data memory (`Memoria_Datos`). That memory indexes on `address[31:2]` and has no byte enables.
- Accepts byte, halfword and word loads/stores from the core.
- Sub-word loads: selects the lane and applies sign/zero extension.
- Sub-word stores: performed as read-modify-write.
- Detects misaligned and out-of-range accesses, which are never issued to memory.

Parameters:
- MEM_WORDS, 256: number of 32-bit words in data memory. A word index `address[31:2] >= MEM_WORDS` is out of range.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; a request is taken on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_address  in  32  byte address.
- req_write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: misaligned, illegal size or out of range.
- mem_read  out  1  to memory `read`.
- mem_write  out  1  to memory `write`.
- mem_address  out  32  word-aligned address, bits [1:0] always 0.
- mem_write_data  out  32  to memory `write_data`.
- mem_read_data  in  32  from memory `read_data`; combinational, 0 when not reading.

Behaviour:
- Request capture: on accept, latch write, size, unsigned, address and data into registers. Later changes on req_* have no effect.
- Reset (sampled reset==0 on an edge):
  - State returns to IDLE; all registers cleared.
  - Outputs after that edge: req_ready=1, resp_valid=0, resp_data=0, resp_error=0, all mem_* = 0.
  - mem_read and mem_write are gated with reset, so no memory write occurs on an edge where reset is low. An in-progress operation is aborted with no response.
- States:
  - IDLE: req_ready=1. On accept:
    - error → DONE with error latched;
    - word store → WRITE;
    - otherwise → READ.
  - READ: mem_read=1, mem_address={addr[31:2],2'b00}. Capture mem_read_data at the edge.
    - load → DONE with extracted result;
    - sub-word store → WRITE with the captured word held.
  - WRITE: mem_write=1, mem_read=0, mem_write_data = merged word (or full word). → DONE.
  - DONE: resp_valid=1 for exactly one cycle, req_ready=0. → IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- No back-pressure on the response. A new request can be accepted in the cycle after DONE.
- Error conditions (no mem_read/mem_write ever asserted):
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size 11;
  - addr[31:2] ≥ MEM_WORDS.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k] with k = addr[1:0];
  - half = [15:0] if addr[1]=0, else [31:16].
- Merge: replace only the addressed lane in the captured word; other bits are unchanged.
- Extension:
  - signed byte: replicate bit 7 up to bit 31;
  - signed half: replicate bit 15 up to bit 31;
  - unsigned: zero-fill.
- Invariants:
  - mem_read and mem_write are never high together.
  - All mem_* outputs are 0 in IDLE and DONE.
  - resp_data and resp_error are registered and remain 0 outside DONE.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - state encoding IDLE/READ/WRITE/DONE;
  - WORD_BYTES=4.
- One combinational sub-module, lane_align:
  - inputs: word, addr[1:0], size, unsigned, store data;
  - outputs: extended load value and merged store word.
  - Reused by both paths; unit-testable on its own.

Test Plan:
- Preload word 4 (addr 0x10) = 0x80FF7F01.
  - Signed byte load at 0x13 → resp_data=0xFFFFFF80.
  - Unsigned byte load at 0x13 → 0x00000080.
  - Each response arrives 2 cycles after accept, with mem_read high for exactly 1 cycle.
- Halfword store 0xBEEF at 0x12 over 0x80FF7F01:
  - expect mem_read for 1 cycle, then mem_write for 1 cycle with mem_write_data=0xBEEF7F01;
  - then a word load at 0x10 returns 0xBEEF7F01.
- Byte store 0xAA at 0x11 → memory word 0x80FFAA01.
  - Signed half load at 0x10 → 0xFFFFAA01.
  - Unsigned half load at 0x10 → 0x0000AA01.
- Word load at 0x12, then half store at 0x401 (misaligned), then byte load at 0x400 (word 256, out of range):
  - each gives resp_error=1, resp_data=0, resp_valid 1 cycle after accept;
  - mem_read and mem_write stay 0 throughout.
- Hold req_valid high with a new request while busy:
  - not accepted until the cycle after DONE (req_ready=1);
  - responses are delivered in order.
- Drive reset low during the WRITE cycle of a byte store:
  - no write on that edge and memory is unchanged;
  - next cycle: IDLE, req_ready=1, resp_valid never pulsed.
